// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - pipeline/trap sequencer signal bundle
// Purpose: groups every non-clock, non-reset signal of trap_sequencer.
// Modports:
//   master - the trap sequencer: consumes pipeline/CSR status, drives stall/flush/redirect/trap info
//   slave  - the pipeline/CSR side: drives status, consumes sequencer outputs
interface trap_sequencer_if;
    logic        XB_bubble;
    logic [31:0] XB_pc;
    logic        initiate_exception;
    logic        mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        mem_busy;
    logic        fetch_ready;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_taken;
    logic        trap_is_irq;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc;
    logic        mie;
    logic        mpie;
    logic        busy;

    modport master (
        input  XB_bubble, XB_pc, initiate_exception, mret, irq_ext, irq_timer,
               mem_busy, fetch_ready, csr_mtvec, csr_mepc,
        output stall, flush, redirect_valid, redirect_pc, trap_taken, trap_is_irq,
               trap_cause, trap_epc, mie, mpie, busy
    );

    modport slave (
        output XB_bubble, XB_pc, initiate_exception, mret, irq_ext, irq_timer,
               mem_busy, fetch_ready, csr_mtvec, csr_mepc,
        input  stall, flush, redirect_valid, redirect_pc, trap_taken, trap_is_irq,
               trap_cause, trap_epc, mie, mpie, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - sequences exception entry, interrupt entry and MRET return
// Purpose: accepts one control-flow diversion at a time (exception > interrupt > MRET),
//   drains outstanding memory ops, flushes FD/XB for FLUSH_CYCLES cycles, then
//   presents a single PC redirect to fetch. Owns the MIE/MPIE enable pair.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - trap_sequencer_if.master (pipeline status, CSR targets, stall/flush/redirect, trap info)
// Parameters:
//   FLUSH_CYCLES - cycles flush is held (1..15)
//   RESET_MIE    - MIE value after reset
// Optional feature macro: TRAP_VECTORED_IRQ_EN
//   defined   - interrupts redirect to csr_mtvec + 4*cause
//   undefined - every trap redirects to csr_mtvec
module trap_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          RESET_MIE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] CAUSE_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        taken_q, taken_d;
    logic        is_irq_q, is_irq_d;
    logic [3:0]  cause_q, cause_d;

    logic        can_accept;
    logic        acc_exc;
    logic        acc_irq;
    logic        acc_ret;
    logic        accept;
    logic [3:0]  irq_cause;
    logic [31:0] trap_target;

    // Acceptance decode. Reset masks it so stall stays low while reset is held.
    always_comb begin
        can_accept = (state_q == IDLE) & ~reset;
        acc_exc    = can_accept & bus.initiate_exception;
        acc_irq    = can_accept & ~bus.XB_bubble & mie_q & (bus.irq_ext | bus.irq_timer)
                     & ~bus.initiate_exception;
        acc_ret    = can_accept & ~bus.XB_bubble & bus.mret & ~bus.initiate_exception & ~acc_irq;
        accept     = acc_exc | acc_irq | acc_ret;
        irq_cause  = bus.irq_ext ? CAUSE_EXT : CAUSE_TIMER;
`ifdef TRAP_VECTORED_IRQ_EN
        trap_target = acc_irq ? (bus.csr_mtvec + {26'd0, irq_cause, 2'b00}) : bus.csr_mtvec;
`else
        trap_target = bus.csr_mtvec;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        taken_d  = 1'b0;
        is_irq_d = is_irq_q;
        cause_d  = cause_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.mem_busy ? DRAIN : FLUSH;
                    cnt_d   = FLUSH_LOAD;
                    if (acc_ret) begin
                        pc_d   = bus.csr_mepc;
                        mie_d  = mpie_q;
                        mpie_d = 1'b1;
                    end else begin
                        pc_d     = trap_target;
                        taken_d  = 1'b1;
                        is_irq_d = acc_irq;
                        cause_d  = acc_irq ? irq_cause : 4'd0;
                        mpie_d   = mie_q;
                        mie_d    = 1'b0;
                        if (acc_irq) begin
                            epc_d = bus.XB_pc;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!bus.mem_busy) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Counter was loaded with FLUSH_CYCLES-1, so flush spans exactly FLUSH_CYCLES cycles.
                if (cnt_q == 4'd0) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                if (bus.fetch_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            mie_q    <= RESET_MIE;
            mpie_q   <= 1'b1;
            pc_q     <= 32'd0;
            epc_q    <= 32'd0;
            taken_q  <= 1'b0;
            is_irq_q <= 1'b0;
            cause_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            taken_q  <= taken_d;
            is_irq_q <= is_irq_d;
            cause_q  <= cause_d;
        end
    end

    assign bus.stall          = accept | (state_q != IDLE);
    assign bus.flush          = (state_q == FLUSH);
    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.redirect_pc    = pc_q;
    assign bus.trap_taken     = taken_q;
    assign bus.trap_is_irq    = is_irq_q;
    assign bus.trap_cause     = cause_q;
    assign bus.trap_epc       = epc_q;
    assign bus.mie            = mie_q;
    assign bus.mpie           = mpie_q;
    assign bus.busy           = (state_q != IDLE);

endmodule
